// File: rtl/inst_fetch.sv
// inst_fetch
//   Instruction-fetch stage feeding IF/ID. Keeps the PC and a direct-mapped,
//   one-word-per-line instruction cache. On a cache hit it presents one
//   instruction per cycle. On a miss it raises a level request to the memory
//   controller and refills the line when the word arrives.
//
// Ports
//   clk_in             clock; all state updates on the rising edge
//   rst_in             synchronous active-high reset
//   stall_in           downstream stall; hold the presented instruction
//   branch_in          one-cycle redirect request
//   branch_addr_in     redirect target (bits [1:0] are ignored)
//   mem_inst_valid_in  one-cycle pulse: mem_inst_in holds the requested word
//   mem_inst_in        word returned by the memory controller
//   mem_req_out        registered level request to the memory controller
//   mem_addr_out       word address of the request; stable while requesting
//   inst_valid_out     inst_out/pc_out hold a valid instruction
//   inst_out           fetched instruction
//   pc_out             address of inst_out

module inst_fetch #(
  parameter int          ICACHE_LINES = 128,
  parameter logic [31:0] RESET_PC     = 32'h0000_0000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        stall_in,
  input  logic        branch_in,
  input  logic [31:0] branch_addr_in,
  input  logic        mem_inst_valid_in,
  input  logic [31:0] mem_inst_in,
  output logic        mem_req_out,
  output logic [31:0] mem_addr_out,
  output logic        inst_valid_out,
  output logic [31:0] inst_out,
  output logic [31:0] pc_out
);

  localparam int INDEX_BITS = $clog2(ICACHE_LINES);
  localparam int TAG_BITS   = 30 - INDEX_BITS;

  typedef enum logic {S_FETCH, S_MISS} state_t;

  state_t                  state;
  logic [31:0]             pc;
  logic [ICACHE_LINES-1:0] line_valid;
  logic [TAG_BITS-1:0]     tag_mem  [ICACHE_LINES];
  logic [31:0]             data_mem [ICACHE_LINES];

  logic [INDEX_BITS-1:0]   pc_index;
  logic [TAG_BITS-1:0]     pc_tag;
  logic [INDEX_BITS-1:0]   fill_index;
  logic [TAG_BITS-1:0]     fill_tag;
  logic                    hit;
  logic                    fill;

  // Lookup works on the internal PC. The refill address is always the
  // latched request address, because a branch may already have moved the PC
  // away by the time the word comes back.
  assign pc_index   = pc[INDEX_BITS+1:2];
  assign pc_tag     = pc[31:INDEX_BITS+2];
  assign fill_index = mem_addr_out[INDEX_BITS+1:2];
  assign fill_tag   = mem_addr_out[31:INDEX_BITS+2];
  assign hit        = line_valid[pc_index] && (tag_mem[pc_index] == pc_tag);
  assign fill       = (state == S_MISS) && mem_inst_valid_in;

  // Tag and data arrays carry no reset; the valid bits alone decide whether
  // a line may be used.
  always_ff @(posedge clk_in) begin
    if (!rst_in && fill) begin
      tag_mem[fill_index]  <= fill_tag;
      data_mem[fill_index] <= mem_inst_in;
    end
  end

  // Fetch control. A returning word is always written, even when a branch
  // arrives in the same cycle, because the data is correct for its address.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state          <= S_FETCH;
      pc             <= RESET_PC;
      line_valid     <= '0;
      mem_req_out    <= 1'b0;
      mem_addr_out   <= '0;
      inst_valid_out <= 1'b0;
      inst_out       <= '0;
      pc_out         <= '0;
    end else begin
      if (fill) begin
        line_valid[fill_index] <= 1'b1;
      end

      if (branch_in) begin
        // Abandons any outstanding read; the controller restarts on its own
        // once the request is dropped.
        pc             <= branch_addr_in & ~32'd3;
        inst_valid_out <= 1'b0;
        mem_req_out    <= 1'b0;
        state          <= S_FETCH;
      end else if (state == S_MISS) begin
        // The request stays high through the valid cycle and drops the cycle
        // after, so only one word is ever consumed per miss.
        if (mem_inst_valid_in) begin
          mem_req_out <= 1'b0;
          state       <= S_FETCH;
        end
      end else if (!stall_in) begin
        if (hit) begin
          inst_valid_out <= 1'b1;
          inst_out       <= data_mem[pc_index];
          pc_out         <= pc;
          pc             <= pc + 32'd4;
        end else begin
          mem_req_out    <= 1'b1;
          mem_addr_out   <= pc;
          inst_valid_out <= 1'b0;
          state          <= S_MISS;
        end
      end
    end
  end

endmodule
